vec_argmax: RTL and testbench
=============================

# vec_argmax

Streaming arg-max stage that sits directly downstream of the dot-product engine and consumes its output vector. It accepts one AXI4-Stream vector of IEEE-754 single-precision values, delimited by TLAST. It tracks the largest element using integer-only ordered compares, with no FPU. It then emits a two-beat result: the winning index followed by the winning value.

## Interface
- COLS, 4, expected vector length; used only for the length check.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- INPUT_AXIS_TDATA  in  32  float32 vector element.
- INPUT_AXIS_TLAST  in  1  marks the final element of the vector.
- INPUT_AXIS_TVALID  in  1  upstream data valid.
- INPUT_AXIS_TREADY  out  1  block can accept an element.
- OUTPUT_AXIS_TDATA  out  32  beat 0 is the winning index (unsigned); beat 1 is the winning value bits.
- OUTPUT_AXIS_TLAST  out  1  high on beat 1 only.
- OUTPUT_AXIS_TVALID  out  1  result beat valid.
- OUTPUT_AXIS_TREADY  in  1  downstream ready.
- FRAME_ERR  out  1  high for the whole output phase when the received beat count != COLS.

## Operation
- States: ST_RECV, ST_OUT_IDX, ST_OUT_VAL.
- ST_RECV:
  - TREADY=1, TVALID=0, TDATA=0.
  - Each accepted beat (TVALID&TREADY) is compared against the running best, then the 32-bit beat counter cnt increments.
  - Accepted beat with TLAST=1 → ST_OUT_IDX.
- ST_OUT_IDX:
  - TREADY=0, TVALID=1, TDATA=best_idx, TLAST=0.
  - TREADY from downstream → ST_OUT_VAL.
- ST_OUT_VAL:
  - TREADY=0, TVALID=1, TDATA=best_val (original input bits), TLAST=1.
  - TREADY from downstream → ST_RECV; cnt, best_idx, best_val, has_best and FRAME_ERR all cleared.
- Compare key:
  - Normalise -0 (0x80000000) to +0 before keying.
  - key = sign ? ~bits : bits ^ 0x80000000.
  - Compare keys as unsigned 32-bit values.
- Element is NaN when exponent==0xFF and mantissa!=0. A NaN never wins and never updates the best.
- Update rule: the first non-NaN element sets the best (has_best=1). A later element replaces the best only if its key is strictly greater, so ties go to the lowest index.
- All-NaN vector: best_idx=0, best_val=bits of element 0.
- Element 0 always loads best_val/best_idx provisionally. Non-NaN elements overwrite it under the rules above.
- ±Inf are ordinary values.
- FRAME_ERR:
  - Registered when the TLAST beat is accepted: (cnt+1) != COLS.
  - Held through ST_OUT_IDX and ST_OUT_VAL; 0 in ST_RECV.
  - Both short and long frames complete normally; only the flag differs.
- There is no frame boundary other than TLAST. A frame longer than COLS keeps comparing, and the index counter is 32 bits.

## Timing
- Reset (sync): state=ST_RECV, cnt=0, has_best=0, best_idx=0, best_val=0.
- Outputs after reset: TREADY=1, TVALID=0, TDATA=0, TLAST=0, FRAME_ERR=0.
- Outputs are decoded combinationally from registered state and registered best/flag; there are no input→output combinational paths except through state.
- Latency: TLAST accepted at edge k → TVALID=1 with the index beat in cycle k+1. With TREADY held high, beat 1 follows in k+2 and TREADY returns in k+3.
- Minimum cost per frame: N input cycles + 2 output cycles.
- Backpressure:
  - While TVALID=1 and TREADY=0, TDATA/TLAST/FRAME_ERR hold stable.
  - No input is accepted during the output phase.
- Upstream stalls (TVALID=0) in ST_RECV leave all state unchanged.
- rst mid-frame or mid-output: the partial result is discarded, and outputs take reset values from the next cycle on.

## Test plan
- Dot-engine vector [3.8,4.4,5.0,5.6] (0x40733333,0x408CCCCD,0x40A00000,0x40B33333), TLAST on beat 3 → beat0 TDATA=3, beat1 TDATA=0x40B33333 with TLAST=1, FRAME_ERR=0.
- Ties and negatives:
  - [2.0,2.0,1.0,0.0] → 0 / 0x40000000.
  - [-3.0,-1.0,-2.0,-4.0] → 1 / 0xBF800000.
  - [0x80000000,0x00000000,-1.0,-2.0] → 0 / 0x80000000 (-0 equals +0; lowest index wins).
- Special values:
  - [0x7FC00000,1.0,0x7F800000,2.0] → 2 / 0x7F800000.
  - All four 0x7FC00001 → 0 / 0x7FC00001.
- Length errors:
  - TLAST on beat 2 of [1.0,5.0,3.0] → 1 / 0x40A00000, FRAME_ERR=1 on both beats.
  - 5-beat frame [1,2,3,4,9.0] → 4 / 0x41100000, FRAME_ERR=1.
- Handshake:
  - Random TVALID gaps on input plus OUTPUT_AXIS_TREADY low for 3 cycles on each output beat → output data stable while stalled; INPUT_AXIS_TREADY=0 throughout the output phase.
  - Back-to-back frames give correct independent results.
- Reset: assert rst after 2 of 4 beats, then send [0.5,0.25,0.125,0.0] → 0 / 0x3F000000, with no residue from the aborted frame.

Source files
------------

// File: rtl/vec_argmax.sv
// Streaming arg-max over one TLAST-delimited vector of float32 values.
// Ordering uses an integer key transform, so no floating-point unit is needed.
// The result leaves as two beats: the winning index, then the winning value bits.
module vec_argmax #(
  parameter int unsigned COLS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] INPUT_AXIS_TDATA,
  input  logic        INPUT_AXIS_TLAST,
  input  logic        INPUT_AXIS_TVALID,
  output logic        INPUT_AXIS_TREADY,
  output logic [31:0] OUTPUT_AXIS_TDATA,
  output logic        OUTPUT_AXIS_TLAST,
  output logic        OUTPUT_AXIS_TVALID,
  input  logic        OUTPUT_AXIS_TREADY,
  output logic        FRAME_ERR
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    ST_RECV    = 2'd0,
    ST_OUT_IDX = 2'd1,
    ST_OUT_VAL = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] cnt;
  logic [DW-1:0] best_idx;
  logic [DW-1:0] best_val;
  logic          has_best;
  logic          frame_err_q;

  // Map float bits onto an unsigned key whose order matches numeric order; -0 folds onto +0
  function automatic logic [DW-1:0] fkey(input logic [DW-1:0] b);
    logic [DW-1:0] n;
    n = (b == 32'h8000_0000) ? '0 : b;
    return n[DW-1] ? ~n : (n ^ 32'h8000_0000);
  endfunction

  logic          in_fire;
  logic          in_nan;
  logic          in_wins;

  // Classify the incoming element and decide whether it displaces the running best
  always_comb begin
    in_fire = (state == ST_RECV) && INPUT_AXIS_TVALID;
    in_nan  = (INPUT_AXIS_TDATA[30:23] == 8'hFF) && (INPUT_AXIS_TDATA[22:0] != 23'd0);
    in_wins = !in_nan && (!has_best || (fkey(INPUT_AXIS_TDATA) > fkey(best_val)));
  end

  // Frame sequencing, running best tracking and result hand-off
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RECV;
      cnt         <= '0;
      best_idx    <= '0;
      best_val    <= '0;
      has_best    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      case (state)
        ST_RECV: begin
          if (in_fire) begin
            if (in_wins) begin
              best_val <= INPUT_AXIS_TDATA;
              best_idx <= cnt;
              has_best <= 1'b1;
            end else if (cnt == '0) begin
              // element 0 is loaded provisionally so an all-NaN vector still reports something
              best_val <= INPUT_AXIS_TDATA;
              best_idx <= '0;
            end
            cnt <= cnt + DW'(1);
            if (INPUT_AXIS_TLAST) begin
              state       <= ST_OUT_IDX;
              frame_err_q <= ((cnt + DW'(1)) != DW'(COLS));
            end
          end
        end
        ST_OUT_IDX: begin
          if (OUTPUT_AXIS_TREADY) state <= ST_OUT_VAL;
        end
        ST_OUT_VAL: begin
          if (OUTPUT_AXIS_TREADY) begin
            state       <= ST_RECV;
            cnt         <= '0;
            best_idx    <= '0;
            best_val    <= '0;
            has_best    <= 1'b0;
            frame_err_q <= 1'b0;
          end
        end
        default: state <= ST_RECV;
      endcase
    end
  end

  // Output decode from registered state and result only
  always_comb begin
    INPUT_AXIS_TREADY  = (state == ST_RECV);
    OUTPUT_AXIS_TVALID = (state == ST_OUT_IDX) || (state == ST_OUT_VAL);
    OUTPUT_AXIS_TLAST  = (state == ST_OUT_VAL);
    FRAME_ERR          = frame_err_q;
    OUTPUT_AXIS_TDATA  = '0;
    if (state == ST_OUT_IDX) OUTPUT_AXIS_TDATA = best_idx;
    if (state == ST_OUT_VAL) OUTPUT_AXIS_TDATA = best_val;
  end

endmodule

// File: tb/tb_vec_argmax.sv
// Scoreboard bench for vec_argmax: stimulus pushes expected beats, a monitor pops and compares.
module tb_vec_argmax;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        frame_err;

  vec_argmax #(.COLS(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .INPUT_AXIS_TDATA   (in_data),
    .INPUT_AXIS_TLAST   (in_last),
    .INPUT_AXIS_TVALID  (in_valid),
    .INPUT_AXIS_TREADY  (in_ready),
    .OUTPUT_AXIS_TDATA  (out_data),
    .OUTPUT_AXIS_TLAST  (out_last),
    .OUTPUT_AXIS_TVALID (out_valid),
    .OUTPUT_AXIS_TREADY (out_ready),
    .FRAME_ERR          (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  beat_t       sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] vec [8];
  bit          stall_mode = 1'b0;
  int          wait_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one frame of n beats and queue its expected two-beat result
  task automatic send_frame(input int n, input logic [31:0] exp_idx, input logic [31:0] exp_val,
                            input logic exp_err, input int gap_max);
    int budget;
    sb.push_back('{data: exp_idx, last: 1'b0, err: exp_err});
    sb.push_back('{data: exp_val, last: 1'b1, err: exp_err});
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk);
          #1;
        end
      end
      in_data  = vec[i];
      in_last  = (i == n - 1);
      in_valid = 1'b1;
      budget   = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        budget++;
        if (budget > 200) begin
          $display("FAIL input_accept_timeout: got tready=0 expected tready=1 within 200 cycles");
          $fatal(1, "input stalled");
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Downstream ready: always high, or 3 stall cycles per output beat
  always @(posedge clk) begin
    #2;
    if (!stall_mode) out_ready = 1'b1;
    else if (out_valid) begin
      if (wait_cnt < 3) begin
        out_ready = 1'b0;
        wait_cnt++;
      end else begin
        out_ready = 1'b1;
        wait_cnt  = 0;
      end
    end else begin
      out_ready = 1'b0;
      wait_cnt  = 0;
    end
  end

  // Monitor: compare transferred beats with the scoreboard, check stability while stalled
  logic        prev_stalled = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  logic        prev_err;
  beat_t       exp_b;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", 32'(out_last), 32'(prev_last));
        chk("stall_err", 32'(frame_err), 32'(prev_err));
      end
      prev_stalled = 1'b0;
      if (out_valid) begin
        chk("in_ready_in_output", 32'(in_ready), 32'd0);
        if (out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got 0x%08h expected no output", out_data);
          end else begin
            exp_b = sb.pop_front();
            chk("out_data", out_data, exp_b.data);
            chk("out_last", 32'(out_last), 32'(exp_b.last));
            chk("frame_err", 32'(frame_err), 32'(exp_b.err));
          end
        end else begin
          prev_stalled = 1'b1;
          prev_data    = out_data;
          prev_last    = out_last;
          prev_err     = frame_err;
        end
      end
    end
  end

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    int budget;
    rst = 1'b1; in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_idle("reset");
    @(posedge clk); #1;

    // Dot-engine vector
    vec = '{32'h40733333, 32'h408CCCCD, 32'h40A00000, 32'h40B33333, 0, 0, 0, 0};
    send_frame(4, 32'd3, 32'h40B33333, 1'b0, 0);
    // Ties go to lowest index
    vec = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h00000000, 0, 0, 0, 0};
    send_frame(4, 32'd0, 32'h40000000, 1'b0, 0);
    // All negative
    vec = '{32'hC0400000, 32'hBF800000, 32'hC0000000, 32'hC0800000, 0, 0, 0, 0};
    send_frame(4, 32'd1, 32'hBF800000, 1'b0, 0);
    // -0 ties +0
    vec = '{32'h80000000, 32'h00000000, 32'hBF800000, 32'hC0000000, 0, 0, 0, 0};
    send_frame(4, 32'd0, 32'h80000000, 1'b0, 0);
    // NaN skipped, +Inf wins
    vec = '{32'h7FC00000, 32'h3F800000, 32'h7F800000, 32'h40000000, 0, 0, 0, 0};
    send_frame(4, 32'd2, 32'h7F800000, 1'b0, 0);
    // All NaN
    vec = '{32'h7FC00001, 32'h7FC00001, 32'h7FC00001, 32'h7FC00001, 0, 0, 0, 0};
    send_frame(4, 32'd0, 32'h7FC00001, 1'b0, 0);
    // Short frame
    vec = '{32'h3F800000, 32'h40A00000, 32'h40400000, 0, 0, 0, 0, 0};
    send_frame(3, 32'd1, 32'h40A00000, 1'b1, 0);
    // Long frame
    vec = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41100000, 0, 0, 0};
    send_frame(5, 32'd4, 32'h41100000, 1'b1, 0);

    // Handshake: input gaps and downstream stalls
    stall_mode = 1'b1;
    vec = '{32'h3F800000, 32'hC0000000, 32'h40400000, 32'h40000000, 0, 0, 0, 0};
    send_frame(4, 32'd2, 32'h40400000, 1'b0, 3);
    vec = '{32'h3F800000, 32'h40A00000, 32'h40400000, 0, 0, 0, 0, 0};
    send_frame(3, 32'd1, 32'h40A00000, 1'b1, 2);
    budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    stall_mode = 1'b0;
    @(posedge clk); #1;

    // Reset mid-frame discards the partial result
    in_data = 32'h7F800000; in_last = 1'b0; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk_idle("midreset");
    @(posedge clk); #1;
    vec = '{32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h00000000, 0, 0, 0, 0};
    send_frame(4, 32'd0, 32'h3F000000, 1'b0, 0);

    budget = 0;
    while (sb.size() != 0 && budget < 500) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
